// File: rtl/rv16_div_unit.sv
// rv16_div_unit: iterative radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU
module rv16_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [1:0]      div_op,
  output logic [XLEN-1:0] result,
  output logic            done,
  output logic            busy
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  localparam int CW = $clog2(XLEN + 1);
  state_t          state;
  logic [XLEN:0]   rem;
  logic [XLEN-1:0] quo, dvs;
  logic [CW-1:0]   cnt;
  logic [1:0]      op;
  logic            q_neg, r_neg, special;
  logic            sgn, bz, ovf, fix_neg;
  logic [XLEN-1:0] abs_a, abs_b, sel;
  logic [XLEN:0]   rem_sh;
  logic [XLEN+1:0] trial;
  // operand conditioning, one restoring step, and final sign selection
  always_comb begin
    sgn     = ~div_op[0];
    bz      = op_b == '0;
    ovf     = sgn && op_a == {1'b1, {(XLEN-1){1'b0}}} && &op_b;
    abs_a   = (sgn && op_a[XLEN-1]) ? -op_a : op_a;
    abs_b   = (sgn && op_b[XLEN-1]) ? -op_b : op_b;
    rem_sh  = {rem[XLEN-1:0], quo[XLEN-1]};
    trial   = {rem, quo[XLEN-1]} - {2'b00, dvs};
    sel     = op[1] ? rem[XLEN-1:0] : quo;
    fix_neg = !special && !op[0] && (op[1] ? r_neg : q_neg);
  end
  // control FSM and datapath registers; done is a single-cycle pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      cnt     <= '0;
      op      <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      special <= 1'b0;
      result  <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          op      <= div_op;
          q_neg   <= sgn & (op_a[XLEN-1] ^ op_b[XLEN-1]);
          r_neg   <= sgn & op_a[XLEN-1];
          dvs     <= abs_b;
          cnt     <= CW'(XLEN);
          busy    <= 1'b1;
          special <= bz | ovf;
          quo     <= bz ? '1 : ovf ? op_a : abs_a;
          rem     <= bz ? {1'b0, op_a} : '0;
          state   <= (bz | ovf) ? FIX : CALC;
        end
        CALC: begin
          rem   <= trial[XLEN+1] ? rem_sh : trial[XLEN:0];
          quo   <= {quo[XLEN-2:0], ~trial[XLEN+1]};
          cnt   <= cnt - CW'(1);
          state <= (cnt == CW'(1)) ? FIX : CALC;
        end
        FIX: begin
          result <= fix_neg ? -sel : sel;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rv16_div_unit.sv
// tb_rv16_div_unit: vector, corner-case and randomized checks of rv16_div_unit
module tb_rv16_div_unit;
  logic        clk = 0, rst_n = 0, start = 0;
  logic [31:0] op_a = 0, op_b = 0, result;
  logic [1:0]  div_op = 0;
  logic        done, busy;
  int checks = 0, errors = 0;

  rv16_div_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .div_op(div_op), .result(result), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a, b;
    logic [1:0]  op;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    int sa, sb;
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : a;
      sa = int'(a);
      sb = int'(b);
      return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return op[1] ? a % b : a / b;
  endfunction

  function automatic int model_lat(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    if (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
    return 33;
  endfunction

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    start = 1; op_a = a; op_b = b; div_op = op;
    @(posedge clk); #1;
    start = 0; op_a = $urandom; op_b = $urandom; div_op = 2'($urandom);
  endtask

  task automatic wait_done(output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                       output logic [31:0] res, output int lat, output int bcnt);
    @(negedge clk);
    launch(a, b, op);
    wait_done(lat, bcnt);
    res = result;
  endtask

  vec_t vecs[11];

  initial begin
    logic [31:0] res, a, b;
    logic [1:0]  op;
    int lat, bcnt, pulses;
    vecs[0]  = '{32'd100,       32'd7,         2'b01, 32'd14,        33};
    vecs[1]  = '{32'hFFFF_FFEC, 32'd3,         2'b00, 32'hFFFF_FFFA, 33};
    vecs[2]  = '{32'hFFFF_FFF9, 32'd2,         2'b10, 32'hFFFF_FFFF, 33};
    vecs[3]  = '{32'd7,         32'hFFFF_FFFE, 2'b10, 32'd1,         33};
    vecs[4]  = '{32'hFFFF_FFFF, 32'd16,        2'b11, 32'd15,        33};
    vecs[5]  = '{32'd5,         32'd0,         2'b01, 32'hFFFF_FFFF, 1};
    vecs[6]  = '{32'hFFFF_FFFB, 32'd0,         2'b00, 32'hFFFF_FFFF, 1};
    vecs[7]  = '{32'd5,         32'd0,         2'b11, 32'd5,         1};
    vecs[8]  = '{32'hFFFF_FFFB, 32'd0,         2'b10, 32'hFFFF_FFFB, 1};
    vecs[9]  = '{32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 32'h8000_0000, 1};
    vecs[10] = '{32'h8000_0000, 32'hFFFF_FFFF, 2'b10, 32'h0,         1};

    #1;
    check("reset_result", result, 0);
    check("reset_done", 32'(done), 0);
    check("reset_busy", 32'(busy), 0);
    repeat (2) @(negedge clk);
    rst_n = 1;

    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].op, res, lat, bcnt);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'(vecs[i].lat));
      @(posedge clk); #1;
      check($sformatf("vec%0d_done_cleared", i), 32'(done), 0);
      check($sformatf("vec%0d_result_held", i), result, vecs[i].exp);
    end

    // start pulse while busy must be ignored
    @(negedge clk);
    launch(32'd100, 32'd7, 2'b01);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1; op_a = 9; op_b = 3; div_op = 2'b01;
    @(negedge clk);
    start = 0;
    pulses = 0;
    res = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done) begin pulses++; res = result; end
    end
    check("busy_start_pulses", 32'(pulses), 1);
    check("busy_start_result", res, 14);

    // start in the done cycle is accepted back-to-back
    do_op(32'd100, 32'd7, 2'b01, res, lat, bcnt);
    check("b2b_first", res, 14);
    launch(32'd9, 32'd3, 2'b01);
    wait_done(lat, bcnt);
    check("b2b_second", result, 3);
    check("b2b_latency", 32'(lat), 33);

    // reset in the middle of an operation
    @(negedge clk);
    launch(32'd100, 32'd7, 2'b01);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 0;
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_result", result, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    pulses = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("midrst_no_done", 32'(pulses), 0);
    do_op(32'd9, 32'd3, 2'b01, res, lat, bcnt);
    check("midrst_fresh", res, 3);

    // randomized against the arithmetic model
    for (int n = 0; n < 200; n++) begin
      a = $urandom;
      op = 2'($urandom);
      case ($urandom_range(0, 4))
        0: b = $urandom;
        1: b = $urandom_range(0, 15);
        2: b = -$urandom_range(1, 15);
        3: begin a = 32'h8000_0000; b = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : $urandom; end
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      do_op(a, b, op, res, lat, bcnt);
      check($sformatf("rand%0d_op%0d_%h_%h", n, op, a, b), res, model(a, b, op));
      check($sformatf("rand%0d_latency", n), 32'(lat), 32'(model_lat(a, b, op)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rv16_div_unit.md
Name: rv16_div_unit

Overview:
- Iterative radix-2 restoring divider for the RV16 execute stage.
- Implements RISC-V M-extension DIV, DIVU, REM and REMU.
- Acts as the responder on the same start/busy/done handshake the ALU uses for its multiplier.
- The ALU asserts a one-cycle start with operands. This block computes over XLEN+1 cycles, then returns a registered result with a one-cycle done pulse.

Parameters:
- XLEN, 32, operand and result width in bits; must be ≥ 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request strobe; sampled only in IDLE.
- op_a  input  XLEN  dividend; sampled with start.
- op_b  input  XLEN  divisor; sampled with start.
- div_op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0]); sampled with start.
- result  output  XLEN  quotient or remainder; registered; held until the next accepted start completes.
- done  output  1  one-cycle pulse; result is valid in the same cycle.
- busy  output  1  high from the accepting edge until the completion edge.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, result=0, done=0, busy=0.
  - Internal remainder, quotient, counter and flags all cleared.
  - Reset mid-operation aborts the operation; no done pulse follows release.
- States:
  - IDLE: waiting for start.
  - CALC: iterating.
  - FIX: sign correction and result write.
- IDLE + start=1 at edge T:
  - Latch the operation and the absolute values of the operands. Signed ops take the two's-complement magnitude; unsigned ops use raw values.
  - Record the quotient sign (a[XLEN-1]^b[XLEN-1]) and remainder sign (a[XLEN-1]); both are signed ops only.
  - busy=1 from T.
  - Load counter=XLEN and go to CALC.
  - Special cases go straight to FIX with a special flag instead of entering CALC:
    - Divide by zero (op_b==0): quotient=all ones; remainder=op_a unmodified; no sign fix.
    - Signed overflow (DIV/REM, op_a=100..0, op_b=all ones): quotient=op_a; remainder=0.
- CALC, one iteration per edge:
  - Shift {rem,quo} left by 1.
  - Trial = rem_shifted − divisor, computed XLEN+1 bits wide.
  - If the trial is non-negative: rem=trial and quo[0]=1; otherwise restore, quo[0]=0.
  - Decrement the counter; after XLEN iterations (counter reaches 0) go to FIX.
- FIX, one edge:
  - result = quotient (DIV/DIVU) or remainder (REM/REMU).
  - For signed ops, negate the quotient if the quotient sign is set, and negate the remainder if the remainder sign is set.
  - Special flag set: use the special-case value instead.
  - At this edge: done=1, busy=0, state=IDLE.
- Latency:
  - Normal: start edge T, done high in the cycle after edge T+XLEN+1. busy high for XLEN+1 cycles.
  - Special cases: done after edge T+1; busy high for 1 cycle.
- done is exactly one cycle wide and cleared on the following edge unconditionally.
- start while busy=1: ignored. No queuing, no effect on operands or the op in flight.
- start in the same cycle done=1 is accepted, because state is IDLE. Back-to-back operations therefore have no gap beyond the done cycle.
- Operand inputs are don't-care except in the start cycle.
- Remainder sign always follows the dividend; quotient truncates toward zero.
- Width rules:
  - Internal remainder is XLEN+1 bits.
  - Magnitude of the most-negative dividend is representable unsigned, so no overflow occurs in the datapath.
  - Final negation is XLEN-bit two's complement.

Test Plan:
- DIVU 100/7, start at T → busy=1 for 33 cycles; done pulse one cycle after edge T+33 with result=14 (0x0000000E); next cycle done=0 and result still 14.
- DIV -20/3 (0xFFFFFFEC/3) → 0xFFFFFFFA (−6); REM -7/2 → 0xFFFFFFFF (−1); REM 7/-2 → 1; REMU 0xFFFFFFFF/16 → 15.
- Divide by zero:
  - DIVU 5/0 → 0xFFFFFFFF; DIV -5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5; REM -5/0 → 0xFFFFFFFB.
  - Each: busy 1 cycle, done after edge T+1.
- Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0; both with 2-edge latency.
- Start while busy:
  - Start DIVU 100/7, then pulse start with DIVU 9/3 at T+5 → single done pulse with result 14.
  - Start DIVU 9/3 in the done cycle → accepted; second done gives 3.
- Reset mid-op: assert rst_n=0 at T+10 of a DIVU → busy, done and result read 0 immediately (async); after release no done pulse; a fresh DIVU 9/3 returns 3.
